wb_mtimer_responder: RTL

//  Wishbone classic responder at the far end of the core's peripheral bus (PERIPHERAL_BUS_TYPE = WISHBONE_BUS).

---
 rtl/cva5_config.sv | 36 +++
 rtl/mtimer_counter.sv | 50 +++++
 rtl/wb_mtimer_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cva5_config.sv
// Shared definitions for the machine-timer responder:
// register offsets, window width and the byte-merge helper.
package cva5_config;

    localparam int MTIMER_WINDOW_W = 5;

    typedef enum logic [MTIMER_WINDOW_W-1:0] {
        REG_MSIP    = 5'h00,
        REG_RSVD0   = 5'h04,
        REG_CMP_LO  = 5'h08,
        REG_CMP_HI  = 5'h0C,
        REG_TIME_LO = 5'h10,
        REG_TIME_HI = 5'h14,
        REG_RSVD1   = 5'h18,
        REG_RSVD2   = 5'h1C
    } mtimer_reg_t;

    typedef enum logic {
        BUS_IDLE,
        BUS_RESP
    } bus_state_t;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  sel
    );
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = sel[i] ? new_word[8*i +: 8]
                                      : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mtimer_counter.sv
// Prescaler and 64-bit mtime with byte-writable halves.
// A bus write wins over the tick increment on the same edge.
module mtimer_counter
    import cva5_config::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [3:0]  sel,
    input  logic [31:0] wdata,
    output logic [63:0] mtime,
    output logic        tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) begin
                mtime[31:0] <= byte_merge(mtime[31:0], wdata, sel);
            end
            if (wr_hi) begin
                mtime[63:32] <= byte_merge(mtime[63:32], wdata, sel);
            end
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/wb_mtimer_responder.sv
// Wishbone classic responder for mtime/mtimecmp/msip.
// One transfer per two cycles: accept in IDLE, respond in RESP.
module wb_mtimer_responder
    import cva5_config::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_adr,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_w,
    output logic [31:0] wb_dat_r,
    output logic        wb_ack,
    output logic        wb_err,
    output logic [63:0] mtime,
    output logic        mtip,
    output logic        msip
);

    bus_state_t  state;
    bus_state_t  state_next;
    logic        ack_next;
    logic        err_next;
    logic [31:0] dat_next;
    logic [31:0] rdata;
    logic [63:0] mtimecmp;
    logic        accept;
    logic        in_window;
    logic        wr_en;
    mtimer_reg_t offset;
    logic        tick_unused;
    logic        adr_unused;

    assign in_window = (wb_adr[31:MTIMER_WINDOW_W]
                        == BASE_ADDR[31:MTIMER_WINDOW_W]);
    assign offset = mtimer_reg_t'({wb_adr[MTIMER_WINDOW_W-1:2], 2'b00});
    assign accept = (state == BUS_IDLE) && wb_cyc && wb_stb;
    assign wr_en = accept && in_window && wb_we && (wb_sel != 4'b0000);
    assign adr_unused = ^wb_adr[1:0];

    always_comb begin
        rdata = '0;
        case (offset)
            REG_MSIP:    rdata = {31'b0, msip};
            REG_CMP_LO:  rdata = mtimecmp[31:0];
            REG_CMP_HI:  rdata = mtimecmp[63:32];
            REG_TIME_LO: rdata = mtime[31:0];
            REG_TIME_HI: rdata = mtime[63:32];
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        dat_next   = wb_dat_r;
        case (state)
            BUS_IDLE: begin
                if (accept) begin
                    state_next = BUS_RESP;
                    ack_next   = in_window;
                    err_next   = !in_window;
                    dat_next   = (in_window && !wb_we) ? rdata : '0;
                end
            end
            BUS_RESP: begin
                state_next = BUS_IDLE;
            end
            default: state_next = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BUS_IDLE;
            wb_ack   <= 1'b0;
            wb_err   <= 1'b0;
            wb_dat_r <= '0;
        end else begin
            state    <= state_next;
            wb_ack   <= ack_next;
            wb_err   <= err_next;
            wb_dat_r <= dat_next;
        end
    end

    // mtip lags mtime/mtimecmp by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
            mtip     <= 1'b0;
        end else begin
            mtip <= (mtime >= mtimecmp);
            if (wr_en && offset == REG_CMP_LO) begin
                mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], wb_dat_w, wb_sel);
            end
            if (wr_en && offset == REG_CMP_HI) begin
                mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], wb_dat_w, wb_sel);
            end
            if (wr_en && offset == REG_MSIP && wb_sel[0]) begin
                msip <= wb_dat_w[0];
            end
        end
    end

    mtimer_counter #(
        .PRESCALE(PRESCALE)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_lo (wr_en && offset == REG_TIME_LO),
        .wr_hi (wr_en && offset == REG_TIME_HI),
        .sel   (wb_sel),
        .wdata (wb_dat_w),
        .mtime (mtime),
        .tick  (tick_unused)
    );

endmodule
